systolic_output_deskew: RTL and testbench

//  Drain-side counterpart of the systolic input skew controller. Takes the staircase-skewed
//  per-column results leaving the array bottom and re-aligns them into one row vector per beat.

---
 rtl/systolic_output_deskew_pkg.sv | 19 +
 rtl/systolic_output_deskew_if.sv | 34 +++
 rtl/systolic_output_deskew_fifo.sv | 62 ++++++
 rtl/systolic_output_deskew.sv | 173 +++++++++++++++++
 tb/tb_systolic_output_deskew.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_output_deskew_pkg.sv
// Shared definitions for the systolic output deskew block.
// Holds the dataflow mode encodings, the controller state type and the
// default accumulator width used by the interface and the top level.
package systolic_output_deskew_pkg;

    localparam int DEFAULT_ACC_WIDTH = 32;

    // Dataflow modes: OS results leave the array already aligned,
    // WS results leave as a staircase and must be re-aligned.
    localparam logic MODE_OS = 1'b0;
    localparam logic MODE_WS = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/systolic_output_deskew_if.sv
// Result stream bundle between the array bottom, the deskew block and the
// downstream consumer.
//   in_valid  : column-0 result valid this cycle
//   C_in      : array bottom results, column j at [(j+1)*ACC_WIDTH-1 -: ACC_WIDTH]
//   out_ready : downstream accepts the current beat
//   out_valid : aligned row available
//   C_out     : aligned row, same packing as C_in, zero when out_valid is low
//   out_last  : last row of the current tile
// The slave modport is the deskew block; the master modport is whoever
// feeds the array results and consumes the aligned rows.
interface systolic_output_deskew_if
    import systolic_output_deskew_pkg::*;
#(
    parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH,
    parameter int COLS      = 4
);
    logic                        in_valid;
    logic [ACC_WIDTH*COLS-1:0]   C_in;
    logic                        out_ready;
    logic                        out_valid;
    logic [ACC_WIDTH*COLS-1:0]   C_out;
    logic                        out_last;

    modport master (
        output in_valid, C_in, out_ready,
        input  out_valid, C_out, out_last
    );

    modport slave (
        input  in_valid, C_in, out_ready,
        output out_valid, C_out, out_last
    );

endinterface

// File: rtl/systolic_output_deskew_fifo.sv
// Synchronous FIFO buffering aligned rows (row data plus last flag).
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_push, i_data   : write request and word
//   i_pop            : read request (ignored while empty)
//   o_data           : word at the head of the queue
//   o_full, o_empty  : occupancy flags
//   o_pushAccept     : the write request is taken this cycle
// A write into a full FIFO is still accepted when a read happens in the
// same cycle, so a draining consumer never causes a drop.
module systolic_output_deskew_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_pushAccept
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             w_doPop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign o_empty      = (r_wrPtr == r_rdPtr);
    assign o_full       = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                          (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_doPop      = i_pop && !o_empty;
    assign o_pushAccept = i_push && (!o_full || w_doPop);
    assign o_data       = r_mem[r_rdPtr[AW-1:0]];

    // Storage needs no reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (o_pushAccept) begin
            r_mem[r_wrPtr[AW-1:0]] <= i_data;
        end
    end

    // Read and write pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (o_pushAccept) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/systolic_output_deskew.sv
// Drain-side deskew for a systolic array. In WS mode the per-column results
// arrive as a staircase (column j lags column 0 by j cycles); column j is
// delayed by COLS-1-j registers so a full row lines up, and the valid tag
// follows column 0. In OS mode rows are already aligned and go straight to
// the FIFO. Aligned rows are buffered and handed downstream with valid/ready.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_enable       : run request
//   i_data_flow    : 0 = OS bypass, 1 = WS deskew; latched on IDLE->RUN
//   o_busy         : controller not idle or rows still buffered
//   o_overflow     : sticky, a row was dropped on a full FIFO
//   io (slave)     : result input and aligned row output stream
module systolic_output_deskew
    import systolic_output_deskew_pkg::*;
#(
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    input  logic i_data_flow,
    output logic o_busy,
    output logic o_overflow,
    systolic_output_deskew_if.slave io
);
    localparam int DW   = ACC_WIDTH * COLS;
    localparam int SKEW = COLS - 1;
    localparam int FCW  = $clog2(COLS);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(COLS - 2);
    localparam logic [RW-1:0]  ROW_LAST   = RW'(ROWS - 1);

    state_t          r_state;
    logic            r_mode;
    logic [FCW-1:0]  r_flushCnt;
    logic [SKEW-1:0] r_tag;
    logic [RW-1:0]   r_rowCnt;
    logic            r_overflow;

    logic            w_run;
    logic            w_active;
    logic            w_tagIn;
    logic [DW-1:0]   w_aligned;
    logic [DW-1:0]   w_pushData;
    logic            w_pushValid;
    logic            w_last;
    logic [DW:0]     w_fifoOut;
    logic            w_full;
    logic            w_empty;
    logic            w_pushAccept;

    assign w_run    = (r_state == ST_RUN);
    assign w_active = (r_state != ST_IDLE);

    // Controller: mode is captured only when leaving IDLE; FLUSH lasts
    // COLS-1 cycles so every row already in the delay lines reaches the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_mode     <= MODE_OS;
            r_flushCnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_enable) begin
                        r_state <= ST_RUN;
                        r_mode  <= i_data_flow;
                    end
                end
                ST_RUN: begin
                    if (!i_enable) begin
                        r_state    <= ST_FLUSH;
                        r_flushCnt <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (r_flushCnt == FLUSH_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_flushCnt <= r_flushCnt + FCW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // New rows are only admitted while running; the tag line then keeps
    // shifting through FLUSH so late columns still complete their row.
    assign w_tagIn = w_run && io.in_valid && (r_mode == MODE_WS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag <= '0;
        end else begin
            r_tag[0] <= w_tagIn;
            for (int i = 1; i < SKEW; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Column j waits COLS-1-j cycles; the last column needs no register.
    for (genvar j = 0; j < COLS; j++) begin : g_col
        localparam int D = COLS - 1 - j;
        if (D == 0) begin : g_direct
            assign w_aligned[j*ACC_WIDTH +: ACC_WIDTH] = io.C_in[j*ACC_WIDTH +: ACC_WIDTH];
        end else begin : g_delay
            logic [ACC_WIDTH-1:0] r_line [D];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < D; i++) begin
                        r_line[i] <= '0;
                    end
                end else begin
                    r_line[0] <= io.C_in[j*ACC_WIDTH +: ACC_WIDTH];
                    for (int i = 1; i < D; i++) begin
                        r_line[i] <= r_line[i-1];
                    end
                end
            end

            assign w_aligned[j*ACC_WIDTH +: ACC_WIDTH] = r_line[D-1];
        end
    end

    assign w_pushValid = w_active && ((r_mode == MODE_WS) ? r_tag[SKEW-1]
                                                           : (w_run && io.in_valid));
    assign w_pushData  = (r_mode == MODE_WS) ? w_aligned : io.C_in;
    assign w_last      = (r_rowCnt == ROW_LAST);

    systolic_output_deskew_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_pushValid),
        .i_data       ({w_last, w_pushData}),
        .i_pop        (io.out_ready),
        .o_data       (w_fifoOut),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_pushAccept (w_pushAccept)
    );

    // Row counter moves only on stored rows, so a drop does not shift the
    // tile boundary; overflow latches until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rowCnt   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pushAccept) begin
                r_rowCnt <= w_last ? '0 : r_rowCnt + RW'(1);
            end
            if (w_pushValid && !w_pushAccept) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign io.out_valid = !w_empty;
    assign io.C_out     = w_empty ? '0 : w_fifoOut[DW-1:0];
    assign io.out_last  = !w_empty && w_fifoOut[DW];
    assign o_busy       = w_active || !w_empty;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Directed bench for systolic_output_deskew with ROWS = COLS = 4 and
// 32-bit results: WS deskew, OS bypass, backpressure with overflow, flush,
// asynchronous reset mid-stream and push-while-full-with-pop.
module tb_systolic_output_deskew;

    localparam int ACC_WIDTH = 32;
    localparam int COLS      = 4;
    localparam int DW        = ACC_WIDTH * COLS;

    logic clk;
    logic rstN;
    logic enable;
    logic dataFlow;
    logic busy;
    logic overflow;
    int   assertCount;
    int   failCount;

    systolic_output_deskew_if #(.ACC_WIDTH(ACC_WIDTH), .COLS(COLS)) busIf ();

    systolic_output_deskew #(
        .ACC_WIDTH  (ACC_WIDTH),
        .ROWS       (4),
        .COLS       (COLS),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rstN),
        .i_enable    (enable),
        .i_data_flow (dataFlow),
        .o_busy      (busy),
        .o_overflow  (overflow),
        .io          (busIf)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic df, input logic valid,
                                 input logic [DW-1:0] cin, input logic ready);
        enable          = en;
        dataFlow        = df;
        busIf.in_valid  = valid;
        busIf.C_in      = cin;
        busIf.out_ready = ready;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                               input logic [DW-1:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checkOutput(tag, DW'(obs), DW'(exp));
    endtask

    task automatic checkBeat(input string tag, input logic expValid,
                             input logic [DW-1:0] expData, input logic expLast);
        checkBit({tag, "_valid"}, busIf.out_valid, expValid);
        checkOutput({tag, "_data"}, busIf.C_out, expData);
        checkBit({tag, "_last"}, busIf.out_last, expLast);
    endtask

    // Row k of the WS test: column j carries 0x100*(j+1)+k.
    function automatic logic [DW-1:0] wsRow(input int k);
        logic [DW-1:0] v;
        for (int j = 0; j < COLS; j++) v[j*32 +: 32] = 32'(32'h100 * (j + 1) + k);
        return v;
    endfunction

    // OS row k: {4k, 3k, 2k, k}.
    function automatic logic [DW-1:0] osRow(input int k);
        logic [DW-1:0] v;
        for (int j = 0; j < COLS; j++) v[j*32 +: 32] = 32'((j + 1) * k);
        return v;
    endfunction

    // Generic tagged row for the FIFO tests.
    function automatic logic [DW-1:0] tagRow(input int base, input int r);
        logic [DW-1:0] v;
        for (int j = 0; j < COLS; j++) v[j*32 +: 32] = 32'(base + 16 * r + j);
        return v;
    endfunction

    // Drop enable from RUN: one edge into FLUSH, three FLUSH cycles, then IDLE.
    task automatic goIdle(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        repeat (4) step();
        checkBit({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] cin;
        logic [DW-1:0] expData;
        logic          expValid;
        logic          expLast;
        int            r;

        assertCount = 0;
        failCount   = 0;
        rstN        = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        repeat (2) step();

        $display("[TB] reset state");
        checkBeat("reset", 1'b0, '0, 1'b0);
        checkBit("reset_busy", busy, 1'b0);
        checkBit("reset_overflow", overflow, 1'b0);
        #2 rstN = 1'b1;
        step();

        // ---------------- WS deskew ----------------
        $display("[TB] WS deskew");
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
        step();
        for (int s = 0; s <= 8; s++) begin
            cin = '0;
            for (int j = 0; j < COLS; j++) begin
                if (s - j >= 0 && s - j <= 3) cin[j*32 +: 32] = 32'(32'h100 * (j + 1) + (s - j));
            end
            applyStimulus(1'b1, 1'b1, (s <= 3), cin, 1'b1);
            expValid = (s >= 4 && s <= 7);
            checkBeat($sformatf("ws_c%0d", s), expValid, expValid ? wsRow(s - 4) : '0, (s == 7));
            step();
        end
        goIdle("ws");

        // ---------------- OS bypass ----------------
        $display("[TB] OS bypass");
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        step();
        for (int s = 0; s <= 5; s++) begin
            applyStimulus(1'b1, 1'b0, (s <= 3), (s <= 3) ? osRow(s + 1) : '0, 1'b1);
            expValid = (s >= 1 && s <= 4);
            checkBeat($sformatf("os_c%0d", s), expValid, expValid ? osRow(s) : '0, (s == 4));
            step();
        end

        // ---------------- Backpressure / overflow ----------------
        $display("[TB] backpressure");
        for (int s = 0; s <= 17; s++) begin
            applyStimulus(1'b1, 1'b0, (s <= 8), (s <= 8) ? tagRow(32'hB00000, s + 1) : '0, (s >= 9));
            if (s == 0 || s == 17) begin
                expValid = 1'b0; expData = '0; expLast = 1'b0;
            end else if (s <= 8) begin
                expValid = 1'b1; expData = tagRow(32'hB00000, 1); expLast = 1'b0;
            end else begin
                r = s - 8;
                expValid = 1'b1; expData = tagRow(32'hB00000, r); expLast = (r == 4 || r == 8);
            end
            checkBeat($sformatf("bp_c%0d", s), expValid, expData, expLast);
            checkBit($sformatf("bp_overflow_c%0d", s), overflow, (s >= 9));
            step();
        end
        goIdle("bp");

        // ---------------- Flush ----------------
        $display("[TB] flush");
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
        step();
        for (int s = 0; s <= 7; s++) begin
            cin = '0;
            for (int j = 0; j < COLS; j++) begin
                if (s == j) cin[j*32 +: 32] = 32'(32'hA0 + j);
            end
            applyStimulus((s == 0), 1'b1, (s == 0 || s == 2), cin, 1'b1);
            expValid = (s == 4);
            checkBeat($sformatf("fl_c%0d", s), expValid,
                      expValid ? {32'hA3, 32'hA2, 32'hA1, 32'hA0} : '0, 1'b0);
            checkBit($sformatf("fl_busy_c%0d", s), busy, (s <= 4));
            step();
        end

        // ---------------- Async reset mid-stream ----------------
        $display("[TB] async reset");
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
        step();
        for (int s = 0; s <= 5; s++) begin
            cin = '0;
            for (int j = 0; j < COLS; j++) cin[j*32 +: 32] = 32'(32'h500 + s);
            applyStimulus(1'b1, 1'b1, 1'b1, cin, 1'b1);
            expValid = (s >= 4);
            expData  = '0;
            if (expValid) begin
                for (int j = 0; j < COLS; j++) expData[j*32 +: 32] = 32'(32'h500 + (s - 4) + j);
            end
            checkBeat($sformatf("ar_c%0d", s), expValid, expData, 1'b0);
            if (s == 0) checkBit("ar_overflow_sticky", overflow, 1'b1);
            if (s < 5) step();
        end
        #2 rstN = 1'b0;
        #1;
        checkBeat("ar_in_reset", 1'b0, '0, 1'b0);
        checkBit("ar_in_reset_busy", busy, 1'b0);
        checkBit("ar_in_reset_overflow", overflow, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        step();
        #2 rstN = 1'b1;
        for (int s = 0; s <= 5; s++) begin
            checkBeat($sformatf("ar_post_c%0d", s), 1'b0, '0, 1'b0);
            checkBit($sformatf("ar_post_busy_c%0d", s), busy, 1'b0);
            step();
        end

        // ---------------- Full FIFO with simultaneous push and pop ----------------
        $display("[TB] full with push and pop");
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step();
        for (int s = 0; s <= 17; s++) begin
            applyStimulus(1'b1, 1'b0, (s <= 8), (s <= 8) ? tagRow(32'h600000, s + 1) : '0, (s >= 8));
            if (s == 0 || s == 17) begin
                expValid = 1'b0; expData = '0; expLast = 1'b0;
            end else if (s <= 8) begin
                expValid = 1'b1; expData = tagRow(32'h600000, 1); expLast = 1'b0;
            end else begin
                r = s - 7;
                expValid = 1'b1; expData = tagRow(32'h600000, r); expLast = (r == 4 || r == 8);
            end
            checkBeat($sformatf("fp_c%0d", s), expValid, expData, expLast);
            checkBit($sformatf("fp_overflow_c%0d", s), overflow, 1'b0);
            step();
        end
        goIdle("fp");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
